// File: rtl/riffa_arb_pkg.sv
// Shared definitions for the RIFFA TX arbiter: FSM state encoding,
// beat-width helper and the round-robin pick function.
package riffa_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_OPEN = 3'd2,
        ST_XFER = 3'd3,
        ST_FIN  = 3'd4
    } arb_state_e;

    // Widest requester vector rr_pick handles; callers zero-extend.
    localparam int MAX_REQ = 8;

    // 32-bit words carried by one data beat.
    function automatic int beat_words(input int width);
        return width / 32;
    endfunction

    // First set bit of req[n-1:0] searching upward from ptr with wrap.
    // Returns {found, idx[2:0]}.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [3:0] r;
        int         k;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (!r[3] && req[k[2:0]]) r = {1'b1, k[2:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick from the current request vector,
// pointer register advanced past the winner when the pick is taken.
//   clk_i, rst_ni  clock, async active-low reset
//   req_i          request vector
//   adv_i          pick is being taken this cycle; move pointer past it
//   found_o        some request is set
//   idx_o          winning index
module rr_arbiter
    import riffa_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic          found_o,
    output logic [RW-1:0] idx_o
);

    logic [RW-1:0]      ptr_q, ptr_d;
    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        pick           = rr_pick(req_ext, 3'(ptr_q), N);
    end

    assign found_o = pick[3];
    assign idx_o   = pick[RW-1:0];

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = (idx_o == RW'(N-1)) ? '0 : idx_o + RW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/riffa_tx_arbiter.sv
// Shares one RIFFA TX channel between C_NUM_REQ streaming producers.
// Per-packet round-robin; the winner's length is latched, CHNL_TX raised,
// and the winner's stream is passed through until the packet is complete.
//   REQ/REQ_LEN          per-requester packet request and length (words)
//   REQ_DATA/_VALID/_REN per-requester data stream, REN is one-hot or zero
//   GNT / DONE           grant (ARB..FIN) and completion pulse (FIN)
//   CHNL_TX_*            RIFFA TX channel port
module riffa_tx_arbiter
    import riffa_arb_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int C_NUM_REQ        = 4
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [C_NUM_REQ-1:0]            REQ,
    input  logic [32*C_NUM_REQ-1:0]         REQ_LEN,
    input  logic [C_PCI_DATA_WIDTH*C_NUM_REQ-1:0] REQ_DATA,
    input  logic [C_NUM_REQ-1:0]            REQ_DATA_VALID,
    output logic [C_NUM_REQ-1:0]            REQ_DATA_REN,
    output logic [C_NUM_REQ-1:0]            GNT,
    output logic [C_NUM_REQ-1:0]            DONE,
    output logic                            CHNL_TX_CLK,
    output logic                            CHNL_TX,
    input  logic                            CHNL_TX_ACK,
    output logic                            CHNL_TX_LAST,
    output logic [31:0]                     CHNL_TX_LEN,
    output logic [30:0]                     CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0]     CHNL_TX_DATA,
    output logic                            CHNL_TX_DATA_VALID,
    input  logic                            CHNL_TX_DATA_REN
);

    localparam int W  = C_PCI_DATA_WIDTH;
    localparam int N  = C_NUM_REQ;
    localparam int BW = beat_words(W);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    arb_state_e  state_q, state_d;
    logic [RW-1:0] win_q, win_d;
    logic [31:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [RW-1:0] pick_idx;
    logic [31:0]   pick_len;
    logic          win_vld;
    logic          beat;
    logic [31:0]   cnt_inc;
    logic [RW-1:0] gnt_idx;
    logic          gnt_en;

    rr_arbiter #(.N(N), .RW(RW)) u_rr (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .req_i   (REQ),
        .adv_i   (state_q == ST_ARB && pick_found),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Length of the candidate winner and data/valid of the latched winner.
    always_comb begin
        pick_len     = '0;
        CHNL_TX_DATA = '0;
        win_vld      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == RW'(i)) pick_len = REQ_LEN[32*i +: 32];
            if (win_q == RW'(i)) begin
                CHNL_TX_DATA = REQ_DATA[W*i +: W];
                win_vld      = REQ_DATA_VALID[i];
            end
        end
    end

    assign beat    = (state_q == ST_XFER) && win_vld && CHNL_TX_DATA_REN;
    assign cnt_inc = cnt_q + 32'(BW);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (|REQ) state_d = ST_ARB;
            ST_ARB: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    len_d   = pick_len;
                    cnt_d   = '0;
                    state_d = (pick_len == 32'd0) ? ST_FIN : ST_OPEN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: if (CHNL_TX_ACK) state_d = ST_XFER;
            ST_XFER: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                    // >= so a partial final beat still ends the packet
                    if (cnt_inc >= len_q) state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant is visible from the ARB cycle itself (using the live pick)
    // through FIN, so a zero-length packet still holds GNT for two cycles.
    assign gnt_idx = (state_q == ST_ARB) ? pick_idx : win_q;
    assign gnt_en  = (state_q == ST_ARB && pick_found) || (state_q == ST_OPEN) ||
                     (state_q == ST_XFER) || (state_q == ST_FIN);

    assign GNT          = gnt_en ? (N'(1) << gnt_idx) : '0;
    assign DONE         = (state_q == ST_FIN) ? (N'(1) << win_q) : '0;
    assign REQ_DATA_REN = beat ? (N'(1) << win_q) : '0;

    assign CHNL_TX_CLK        = CLK;
    assign CHNL_TX            = (state_q == ST_OPEN) || (state_q == ST_XFER);
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_LEN        = len_q;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_DATA_VALID = (state_q == ST_XFER) && win_vld;

endmodule
